regfile_access_ctrl: RTL and testbench

//   Initiator side of the register-file strobe/acknowledge protocol. Accepts one

---
 rtl/regfile_access_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Initiator for the regfile strobe/acknowledge protocol: sequences an optional write-back
// and up to two source reads as 4-phase handshakes, then returns operands on valid/ready.
module regfile_access_ctrl #(
    parameter int REG_SZ      = 32,
    parameter int SYNC_STAGES = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              rs_en,
    input  logic [4:0]        rs_idx,
    input  logic              rt_en,
    input  logic [4:0]        rt_idx,
    input  logic              wb_en,
    input  logic [4:0]        wb_idx,
    input  logic [REG_SZ-1:0] wb_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [REG_SZ-1:0] rs_val,
    output logic [REG_SZ-1:0] rt_val,
    output logic              err,
    output logic [4:0]        r_idx,
    output logic [4:0]        w_idx,
    output logic              re,
    output logic              we,
    output logic [REG_SZ-1:0] din,
    input  logic              rack,
    input  logic              wack,
    input  logic [REG_SZ-1:0] dout
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE,
        W_ASSERT,
        W_RELEASE,
        RS_ASSERT,
        RS_RELEASE,
        RT_ASSERT,
        RT_RELEASE,
        RESP
    } state_t;

    state_t                 state_reg;
    state_t                 adv_state;
    logic [4:0]             adv_r_idx;
    logic                   adv_fire;
    logic                   ack_s;
    logic                   tmo_hit;
    logic [TW-1:0]          tmo_cnt_reg;
    logic                   rs_go_reg;
    logic                   rt_go_reg;
    logic [4:0]             rs_idx_reg;
    logic [4:0]             rt_idx_reg;
    logic [SYNC_STAGES-1:0] rack_sync_reg;
    logic [SYNC_STAGES-1:0] rack_sync_next;
    logic [SYNC_STAGES-1:0] wack_sync_reg;
    logic [SYNC_STAGES-1:0] wack_sync_next;

    // Acknowledge synchronisers: stage 0 samples the pin, later stages shift it along.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_head
                assign rack_sync_next[gi] = rack;
                assign wack_sync_next[gi] = wack;
            end else begin : g_tail
                assign rack_sync_next[gi] = rack_sync_reg[gi-1];
                assign wack_sync_next[gi] = wack_sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rack_sync_reg <= '0;
            wack_sync_reg <= '0;
        end else begin
            rack_sync_reg <= rack_sync_next;
            wack_sync_reg <= wack_sync_next;
        end
    end

    assign ack_s   = (state_reg == W_ASSERT || state_reg == W_RELEASE)
                     ? wack_sync_reg[SYNC_STAGES-1] : rack_sync_reg[SYNC_STAGES-1];
    assign tmo_hit = (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));

    // Next phase to enter when the current one completes; idle phases are skipped here.
    always_comb begin
        adv_state = RESP;
        adv_r_idx = r_idx;
        adv_fire  = 1'b0;
        case (state_reg)
            IDLE: begin
                adv_fire = req_valid;
                if (wb_en && wb_idx != 5'd0) begin
                    adv_state = W_ASSERT;
                end else if (rs_en && rs_idx != 5'd0) begin
                    adv_state = RS_ASSERT;
                    adv_r_idx = rs_idx;
                end else if (rt_en && rt_idx != 5'd0) begin
                    adv_state = RT_ASSERT;
                    adv_r_idx = rt_idx;
                end
            end
            W_RELEASE: begin
                adv_fire = !ack_s;
                if (rs_go_reg) begin
                    adv_state = RS_ASSERT;
                    adv_r_idx = rs_idx_reg;
                end else if (rt_go_reg) begin
                    adv_state = RT_ASSERT;
                    adv_r_idx = rt_idx_reg;
                end
            end
            RS_RELEASE: begin
                adv_fire = !ack_s;
                if (rt_go_reg) begin
                    adv_state = RT_ASSERT;
                    adv_r_idx = rt_idx_reg;
                end
            end
            RT_RELEASE: adv_fire = !ack_s;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            err         <= 1'b0;
            re          <= 1'b0;
            we          <= 1'b0;
            r_idx       <= 5'd0;
            w_idx       <= 5'd0;
            din         <= '0;
            rs_val      <= '0;
            rt_val      <= '0;
            tmo_cnt_reg <= '0;
            rs_go_reg   <= 1'b0;
            rt_go_reg   <= 1'b0;
            rs_idx_reg  <= 5'd0;
            rt_idx_reg  <= 5'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        rs_go_reg  <= rs_en && rs_idx != 5'd0;
                        rt_go_reg  <= rt_en && rt_idx != 5'd0;
                        rs_idx_reg <= rs_idx;
                        rt_idx_reg <= rt_idx;
                        w_idx      <= wb_idx;
                        din        <= wb_data;
                        rs_val     <= '0;
                        rt_val     <= '0;
                        err        <= 1'b0;
                        req_ready  <= 1'b0;
                    end
                end
                W_ASSERT, RS_ASSERT, RT_ASSERT: begin
                    if (ack_s) begin
                        if (state_reg == RS_ASSERT) rs_val <= dout;
                        if (state_reg == RT_ASSERT) rt_val <= dout;
                        re          <= 1'b0;
                        we          <= 1'b0;
                        tmo_cnt_reg <= '0;
                        state_reg   <= (state_reg == W_ASSERT)  ? W_RELEASE :
                                       (state_reg == RS_ASSERT) ? RS_RELEASE : RT_RELEASE;
                    end else if (tmo_hit) begin
                        re          <= 1'b0;
                        we          <= 1'b0;
                        err         <= 1'b1;
                        resp_valid  <= 1'b1;
                        tmo_cnt_reg <= '0;
                        state_reg   <= RESP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end
                W_RELEASE, RS_RELEASE, RT_RELEASE: begin
                    if (ack_s) begin
                        if (tmo_hit) begin
                            err         <= 1'b1;
                            resp_valid  <= 1'b1;
                            tmo_cnt_reg <= '0;
                            state_reg   <= RESP;
                        end else begin
                            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                        end
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Entering the next phase: strobe rises on the same edge the phase is entered.
            if (adv_fire) begin
                state_reg   <= adv_state;
                re          <= (adv_state == RS_ASSERT) || (adv_state == RT_ASSERT);
                we          <= (adv_state == W_ASSERT);
                r_idx       <= adv_r_idx;
                resp_valid  <= (adv_state == RESP);
                tmo_cnt_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a zero-delay regfile responder and a
// transaction-level model predicting operands, error flag, latency and strobe pulses.
module tb_regfile_access_ctrl;

    localparam int REG_SZ  = 32;
    localparam int SYNC    = 1;
    localparam int TMO     = 8;
    localparam int ACC_LAT = 2 * (SYNC + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready;
    logic              rs_en, rt_en, wb_en;
    logic [4:0]        rs_idx, rt_idx, wb_idx;
    logic [REG_SZ-1:0] wb_data;
    logic              resp_valid, resp_ready;
    logic [REG_SZ-1:0] rs_val, rt_val;
    logic              err;
    logic [4:0]        r_idx, w_idx;
    logic              re, we;
    logic [REG_SZ-1:0] din, dout;
    logic              rack, wack;
    logic              rack_stuck;

    logic [REG_SZ-1:0] mem   [32];
    logic [REG_SZ-1:0] mregs [32];

    int checks = 0;
    int errors = 0;
    int re_pulses, we_pulses, re_cycles;
    logic re_prev = 1'b0, we_prev = 1'b0;
    bit   model_live = 1'b0;
    logic [REG_SZ-1:0] exp_rs, exp_rt;
    logic exp_err;
    int   exp_lat, exp_re, exp_we;

    always #5 clk = ~clk;

    regfile_access_ctrl #(
        .REG_SZ(REG_SZ), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .rs_en(rs_en), .rs_idx(rs_idx), .rt_en(rt_en), .rt_idx(rt_idx),
        .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .rs_val(rs_val), .rt_val(rt_val), .err(err),
        .r_idx(r_idx), .w_idx(w_idx), .re(re), .we(we), .din(din),
        .rack(rack), .wack(wack), .dout(dout)
    );

    // Zero-delay regfile responder.
    assign rack = re & ~rack_stuck;
    assign wack = we;
    assign dout = mem[r_idx];
    always @(posedge clk) if (we) mem[w_idx] <= din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Every cycle: strobe exclusivity, pulse bookkeeping, and pending-response contents.
    always @(negedge clk) begin
        if (!rst) begin
            if (re && !re_prev) re_pulses++;
            if (we && !we_prev) we_pulses++;
            if (re) re_cycles++;
            check("re_we_exclusive", 32'(re & we), 32'd0);
            if (resp_valid && model_live) begin
                check("rs_val", rs_val, exp_rs);
                check("rt_val", rt_val, exp_rt);
                check("err", 32'(err), 32'(exp_err));
                check("req_ready_busy", 32'(req_ready), 32'd0);
            end
        end
        re_prev = re;
        we_prev = we;
    end

    // Transaction model: write first, then rs, then rt; index 0 / disabled reads yield 0.
    task automatic predict(input logic wbe, input logic [4:0] wbi, input logic [31:0] wbd,
                           input logic rse, input logic [4:0] rsi,
                           input logic rte, input logic [4:0] rti, input bit stuck);
        exp_rs = '0; exp_rt = '0; exp_err = 1'b0;
        exp_lat = 0; exp_re = 0; exp_we = 0;
        if (wbe && wbi != 0) begin
            mregs[wbi] = wbd; exp_we = 1; exp_lat += ACC_LAT;
        end
        if (rse && rsi != 0) begin
            exp_re++;
            if (stuck) begin exp_err = 1'b1; exp_lat += TMO; end
            else begin exp_rs = mregs[rsi]; exp_lat += ACC_LAT; end
        end
        if (rte && rti != 0 && !exp_err) begin
            exp_re++;
            if (stuck) begin exp_err = 1'b1; exp_lat += TMO; end
            else begin exp_rt = mregs[rti]; exp_lat += ACC_LAT; end
        end
    endtask

    task automatic run_txn(input string tag, input logic wbe, input logic [4:0] wbi,
                           input logic [31:0] wbd, input logic rse, input logic [4:0] rsi,
                           input logic rte, input logic [4:0] rti, input int hold,
                           input bit stuck);
        int lat;
        @(negedge clk); #1;
        rack_stuck = stuck;
        predict(wbe, wbi, wbd, rse, rsi, rte, rti, stuck);
        re_pulses = 0; we_pulses = 0; re_cycles = 0;
        model_live = 1'b1;
        wb_en = wbe; wb_idx = wbi; wb_data = wbd;
        rs_en = rse; rs_idx = rsi; rt_en = rte; rt_idx = rti;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_resp_seen"}, 32'(resp_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        repeat (hold) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
        end
        $display("txn %s: lat=%0d rs_val=%h rt_val=%h err=%b re_pulses=%0d we_pulses=%0d",
                 tag, lat, rs_val, rt_val, err, re_pulses, we_pulses);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        model_live = 1'b0;
        rack_stuck = 1'b0;
        check({tag, "_resp_drop"}, 32'(resp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
        check({tag, "_re_pulses"}, 32'(re_pulses), 32'(exp_re));
        check({tag, "_we_pulses"}, 32'(we_pulses), 32'(exp_we));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) begin mem[i] = '0; mregs[i] = '0; end
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; rack_stuck = 1'b0;
        rs_en = 0; rt_en = 0; wb_en = 0; rs_idx = 0; rt_idx = 0; wb_idx = 0; wb_data = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_re_we", {30'd0, re, we}, 32'd0);
        check("rst_resp_err", {30'd0, resp_valid, err}, 32'd0);
        check("rst_vals", rs_val | rt_val | din, 32'd0);
        check("rst_idx", {22'd0, r_idx, w_idx}, 32'd0);
        $display("txn reset: req_ready=%b re=%b we=%b resp_valid=%b", req_ready, re, we, resp_valid);
        rst = 1'b0;

        run_txn("wb5_rs5_rt5", 1, 5, 32'hDEAD, 1, 5, 1, 5, 0, 0);
        check("pin_lat12", 32'(exp_lat), 32'd12);
        check("pin_rs_dead", exp_rs, 32'hDEAD);
        run_txn("wb3", 1, 3, 32'd7, 0, 0, 0, 0, 0, 0);
        run_txn("rs0_rt3", 0, 0, 32'd0, 1, 0, 1, 3, 0, 0);
        check("pin_rt7", exp_rt, 32'd7);
        check("pin_one_re", 32'(exp_re), 32'd1);
        run_txn("wb0", 1, 0, 32'd1, 0, 0, 0, 0, 0, 0);
        check("pin_lat0", 32'(exp_lat), 32'd0);
        run_txn("stall5", 1, 9, 32'h1234_5678, 1, 9, 1, 5, 5, 0);
        run_txn("empty", 0, 0, 32'd0, 0, 7, 0, 3, 0, 0);
        run_txn("timeout", 0, 0, 32'd0, 1, 5, 1, 3, 0, 1);
        check("pin_lat_tmo", 32'(exp_lat), 32'd8);
        check("tmo_re_cycles", 32'(re_cycles), 32'(TMO));
        run_txn("err_clear", 0, 0, 32'd0, 1, 3, 0, 0, 0, 0);

        // Reset while the read strobe is up: strobe drops, no response follows.
        @(negedge clk); #1;
        rs_en = 1; rs_idx = 5; rt_en = 0; wb_en = 0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mid_rst_re_up", 32'(re), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_re_drop", 32'(re), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        n = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (resp_valid) n++;
        end
        check("mid_rst_no_resp", 32'(n), 32'd0);
        $display("txn mid_reset: re=%b req_ready=%b resp_cycles=%0d", re, req_ready, n);

        run_txn("after_rst", 0, 0, 32'd0, 0, 0, 1, 9, 0, 0);
        check("pin_rt_9", exp_rt, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
